// File: rtl/instr_fetch_ctrl_if.sv
// Instruction-memory read bus: the fetch controller drives the strobe and address,
// and memory returns the ready flag and the instruction word.
interface instr_fetch_ctrl_if #(
  parameter int AW = 8
);
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_rdy;
  logic [15:0]   mem_data;

  modport master (output mem_rd, mem_addr, input  mem_rdy, mem_data);
  modport slave  (input  mem_rd, mem_addr, output mem_rdy, mem_data);
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: reads one word per fetch request, handles jumps,
// and flags (stickily) a memory that fails to answer within TIMEOUT cycles.
module instr_fetch_ctrl #(
  parameter int          AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                fetch_req,
  input  logic                jmp,
  input  logic [AW-1:0]       jmp_addr,
  instr_fetch_ctrl_if.master  mem,
  output logic                ir_ld,
  output logic [15:0]         ir_data,
  output logic [AW-1:0]       pc,
  output logic                busy,
  output logic                fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, LOAD, ERR} state_t;

  // Last wait count before expiry; the expiring cycle is the TIMEOUT-th with mem_rdy low.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_wait;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic          r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!jmp && fetch_req) w_next = REQ;
      end
      REQ: begin
        if (jmp)                      w_next = IDLE;
        else if (mem.mem_rdy)         w_next = LOAD;
        else if (r_wait == WAIT_LAST) w_next = ERR;
      end
      LOAD:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_wait <= '0;
          if (jmp) r_pc <= jmp_addr;
        end
        REQ: begin
          if (jmp) begin
            r_pc <= jmp_addr;
          end else if (mem.mem_rdy) begin
            r_ir <= mem.mem_data;
          end else begin
            r_wait <= r_wait + 4'd1;
            if (w_next == ERR) r_err <= 1'b1;
          end
        end
        LOAD: begin
          r_pc   <= r_pc + 1'b1;
          r_wait <= '0;
        end
        default: r_wait <= '0;
      endcase
    end
  end

  assign mem.mem_rd   = (r_state == REQ);
  assign mem.mem_addr = r_pc;
  assign ir_ld        = (r_state == LOAD);
  assign ir_data      = r_ir;
  assign pc           = r_pc;
  assign busy         = (r_state != IDLE);
  assign fetch_err    = r_err;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a behavioural memory answers reads after a chosen wait,
// and each expected instruction load is queued then matched against ir_ld pulses.
module tb_instr_fetch_ctrl;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        fetch_req;
  logic        jmp;
  logic [7:0]  jmp_addr;
  logic        ir_ld;
  logic [15:0] ir_data;
  logic [7:0]  pc;
  logic        busy;
  logic        fetch_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wait_cycles = 0;
  int          rd_cnt = 0;
  int          n_ld;
  exp_t        sb[$];
  logic [7:0]  addr_log[$];

  instr_fetch_ctrl_if #(.AW(8)) mem_if ();

  instr_fetch_ctrl #(.AW(8), .RESET_PC(8'h00), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fetch_req (fetch_req),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .mem       (mem_if),
    .ir_ld     (ir_ld),
    .ir_data   (ir_data),
    .pc        (pc),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return (a == 8'h00) ? 16'hA5C3 : {a, a ^ 8'h5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("idle_bound", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_fetch(input int w, input logic [7:0] a);
    wait_cycles = w;
    sb.push_back('{addr: a, data: mem_word(a)});
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    wait_idle();
  endtask

  // Memory model: raises mem_rdy once mem_rd has been high for wait_cycles cycles.
  initial begin
    mem_if.mem_rdy  = 1'b0;
    mem_if.mem_data = '0;
    forever begin
      @(negedge clk);
      if (mem_if.mem_rd === 1'b1) begin
        addr_log.push_back(mem_if.mem_addr);
        mem_if.mem_rdy  = (rd_cnt >= wait_cycles);
        mem_if.mem_data = mem_word(mem_if.mem_addr);
        rd_cnt++;
      end else begin
        mem_if.mem_rdy  = 1'b0;
        mem_if.mem_data = '0;
        rd_cnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ir_ld === 1'b1) begin
        if (sb.size() == 0) begin
          chk("ir_ld_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ld_ir_data", {16'd0, ir_data}, {16'd0, e.data});
          chk("ld_pc", {24'd0, pc}, {24'd0, e.addr});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; fetch_req = 1'b0; jmp = 1'b0; jmp_addr = '0;
    #3;
    chk("rst_mem_rd", {31'd0, mem_if.mem_rd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ir_ld", {31'd0, ir_ld}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_ir_data", {16'd0, ir_data}, 32'h0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single fetch with an immediate answer.
    @(negedge clk);
    wait_cycles = 0;
    sb.push_back('{addr: 8'h00, data: 16'hA5C3});
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("t1_mem_rd", {31'd0, mem_if.mem_rd}, 32'd1);
    chk("t1_mem_addr", {24'd0, mem_if.mem_addr}, 32'h00);
    @(negedge clk);
    chk("t1_ir_ld", {31'd0, ir_ld}, 32'd1);
    chk("t1_ir_data", {16'd0, ir_data}, 32'hA5C3);
    @(negedge clk);
    chk("t1_ir_ld_off", {31'd0, ir_ld}, 32'd0);
    chk("t1_pc", {24'd0, pc}, 32'h01);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // Jump beats a simultaneous fetch request; next fetch wraps pc.
    jmp = 1'b1; jmp_addr = 8'hFF; fetch_req = 1'b1;
    @(negedge clk);
    jmp = 1'b0; fetch_req = 1'b0;
    chk("t2_pc", {24'd0, pc}, 32'hFF);
    chk("t2_mem_rd", {31'd0, mem_if.mem_rd}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    addr_log.delete();
    do_fetch(0, 8'hFF);
    chk("t2_pc_wrap", {24'd0, pc}, 32'h00);
    chk("t2_log_n", addr_log.size(), 32'd1);
    if (addr_log.size() > 0) chk("t2_log_addr", {24'd0, addr_log[0]}, 32'hFF);

    // Memory never answers: timeout after 15 wait cycles.
    addr_log.delete();
    wait_cycles = 99;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    for (int i = 0; i < 40 && mem_if.mem_rd; i++) @(negedge clk);
    chk("t3_rd_cycles", addr_log.size(), 32'd15);
    chk("t3_fetch_err", {31'd0, fetch_err}, 32'd1);
    chk("t3_mem_rd", {31'd0, mem_if.mem_rd}, 32'd0);
    chk("t3_err_busy", {31'd0, busy}, 32'd1);
    chk("t3_ir_ld", {31'd0, ir_ld}, 32'd0);
    chk("t3_pc", {24'd0, pc}, 32'h00);
    @(negedge clk);
    chk("t3_idle", {31'd0, busy}, 32'd0);
    chk("t3_pc_hold", {24'd0, pc}, 32'h00);
    do_fetch(0, 8'h00);
    chk("t3_pc_after", {24'd0, pc}, 32'h01);
    chk("t3_err_sticky", {31'd0, fetch_err}, 32'd1);

    // Jump during REQ while memory is ready: read is abandoned.
    wait_cycles = 0;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    jmp = 1'b1; jmp_addr = 8'h40;
    chk("t4_in_req", {31'd0, mem_if.mem_rd}, 32'd1);
    @(negedge clk);
    jmp = 1'b0;
    chk("t4_mem_rd", {31'd0, mem_if.mem_rd}, 32'd0);
    chk("t4_ir_ld", {31'd0, ir_ld}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_pc", {24'd0, pc}, 32'h40);
    chk("t4_ir_data", {16'd0, ir_data}, 32'hA5C3);
    @(negedge clk);
    chk("t4_ir_ld_late", {31'd0, ir_ld}, 32'd0);

    // Asynchronous reset in the middle of a read at pc=0x10.
    jmp = 1'b1; jmp_addr = 8'h10;
    @(negedge clk);
    jmp = 1'b0;
    wait_cycles = 99;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("t5_mem_rd", {31'd0, mem_if.mem_rd}, 32'd1);
    chk("t5_mem_addr", {24'd0, mem_if.mem_addr}, 32'h10);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_mem_rd", {31'd0, mem_if.mem_rd}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_pc", {24'd0, pc}, 32'h00);
    chk("t5_rst_ir_ld", {31'd0, ir_ld}, 32'd0);
    chk("t5_rst_ir_data", {16'd0, ir_data}, 32'h0);
    chk("t5_rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // fetch_req held: back-to-back fetches from 0 to 3.
    wait_cycles = 0;
    addr_log.delete();
    for (int a = 0; a < 4; a++) sb.push_back('{addr: 8'(a), data: mem_word(8'(a))});
    n_ld = 0;
    fetch_req = 1'b1;
    for (int i = 0; i < 60 && n_ld < 4; i++) begin
      @(negedge clk);
      if (ir_ld === 1'b1) n_ld++;
    end
    fetch_req = 1'b0;
    @(negedge clk);
    chk("t6_ld_count", n_ld, 32'd4);
    chk("t6_pc", {24'd0, pc}, 32'h04);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_log_n", addr_log.size(), 32'd4);
    for (int a = 0; a < 4 && a < addr_log.size(); a++)
      chk("t6_log_addr", {24'd0, addr_log[a]}, a);

    // Memory answers in the last cycle before timeout: success.
    do_fetch(14, 8'h04);
    chk("t7_pc", {24'd0, pc}, 32'h05);
    chk("t7_fetch_err", {31'd0, fetch_err}, 32'd0);

    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
